// File: rtl/spi_receiver_pkg.sv
// Shared SPI receiver definitions: command FSM states, long-command flag bit and SUMP opcodes
// used by both the receiver and the core command decoder.
package spi_receiver_pkg;

   localparam int SPI_LONG_CMD_BIT  = 7;
   localparam int SPI_BITS_PER_BYTE = 8;

   typedef enum logic [2:0] {
      ST_OPCODE = 3'd0,
      ST_ARG0   = 3'd1,
      ST_ARG1   = 3'd2,
      ST_ARG2   = 3'd3,
      ST_ARG3   = 3'd4,
      ST_EXEC   = 3'd5
   } state_t;

   localparam logic [7:0] SUMP_RESET          = 8'h00;
   localparam logic [7:0] SUMP_RUN            = 8'h01;
   localparam logic [7:0] SUMP_ID             = 8'h02;
   localparam logic [7:0] SUMP_XON            = 8'h11;
   localparam logic [7:0] SUMP_XOFF           = 8'h13;
   localparam logic [7:0] SUMP_SET_DIVIDER    = 8'h80;
   localparam logic [7:0] SUMP_SET_READ_DELAY = 8'h81;

   function automatic logic is_long_cmd(input logic [7:0] opcode);
      return opcode[SPI_LONG_CMD_BIT];
   endfunction

endpackage

// File: rtl/spi_rx_byte.sv
// SPI mode-0 byte deserialiser: synchronises sclk/cs/rx into the system clock domain,
// detects sclk rising edges and shifts MSB-first bits into a byte with a one-cycle strobe.
module spi_rx_byte
   import spi_receiver_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       cs,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_strobe
);

   logic [SYNC_STAGES-1:0] sclk_sync_reg;
   logic [SYNC_STAGES-1:0] cs_sync_reg;
   logic [SYNC_STAGES-1:0] rx_sync_reg;
   logic                   sclk_prev_reg;
   logic [2:0]             bit_cnt_reg;
   logic [6:0]             shift_reg;

   logic sclk_s;
   logic cs_s;
   logic rx_s;
   logic sclk_rise;

   // Idle line state out of reset: sclk low, cs deselected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_reg <= '0;
         cs_sync_reg   <= '1;
         rx_sync_reg   <= '0;
         sclk_prev_reg <= 1'b0;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs};
         rx_sync_reg   <= {rx_sync_reg[SYNC_STAGES-2:0], rx};
         sclk_prev_reg <= sclk_s;
      end
   end

   assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
   assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
   assign rx_s      = rx_sync_reg[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_reg;

   // A deselect seen in the same cycle as an edge drops that bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
      end else if (cs_s) begin
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
      end else if (sclk_rise) begin
         bit_cnt_reg <= bit_cnt_reg + 3'd1;
         shift_reg   <= {shift_reg[5:0], rx_s};
      end
   end

   assign rx_byte     = {shift_reg, rx_s};
   assign byte_strobe = sclk_rise & ~cs_s & (bit_cnt_reg == 3'(SPI_BITS_PER_BYTE - 1));

endmodule

// File: rtl/spi_receiver.sv
// SUMP command receiver over SPI: assembles short/long commands and strobes execute with op/data.
// Optional idle timeout on partial long commands enabled by defining SPI_RX_TIMEOUT_EN.
module spi_receiver
   import spi_receiver_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic        clock,
   input  logic        extReset,
   input  logic        sclk,
   input  logic        cs,
   input  logic        rx,
   output logic [7:0]  op,
   output logic [31:0] data,
   output logic        execute,
   output logic        busy
);

   state_t      state_reg, state_next;
   logic [7:0]  opcode_reg, opcode_next;
   logic [31:0] arg_reg, arg_next;
   logic [7:0]  op_reg;
   logic [31:0] data_reg;
   logic [7:0]  rx_byte;
   logic        byte_strobe;
   logic        arg_state;
   logic        load_out;
   logic        timed_out;

   if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      // Unsupported configuration; left empty so elaboration still reports the block.
   end

   spi_rx_byte #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_rx_byte (
      .clk        (clock),
      .rst        (extReset),
      .sclk       (sclk),
      .cs         (cs),
      .rx         (rx),
      .rx_byte    (rx_byte),
      .byte_strobe(byte_strobe)
   );

   assign arg_state = (state_reg == ST_ARG0) || (state_reg == ST_ARG1) ||
                      (state_reg == ST_ARG2) || (state_reg == ST_ARG3);

`ifdef SPI_RX_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] timer_reg;

   assign timed_out = arg_state && !byte_strobe && (timer_reg == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or posedge extReset) begin
      if (extReset)
         timer_reg <= '0;
      else if (byte_strobe || !arg_state || timed_out)
         timer_reg <= '0;
      else
         timer_reg <= timer_reg + 1'b1;
   end
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      opcode_next = opcode_reg;
      arg_next    = arg_reg;
      case (state_reg)
         ST_OPCODE: if (byte_strobe) begin
            opcode_next = rx_byte;
            arg_next    = '0;
            state_next  = is_long_cmd(rx_byte) ? ST_ARG0 : ST_EXEC;
         end
         ST_ARG0: if (byte_strobe) begin
            arg_next[7:0] = rx_byte;
            state_next    = ST_ARG1;
         end
         ST_ARG1: if (byte_strobe) begin
            arg_next[15:8] = rx_byte;
            state_next     = ST_ARG2;
         end
         ST_ARG2: if (byte_strobe) begin
            arg_next[23:16] = rx_byte;
            state_next      = ST_ARG3;
         end
         ST_ARG3: if (byte_strobe) begin
            arg_next[31:24] = rx_byte;
            state_next      = ST_EXEC;
         end
         ST_EXEC:  state_next = ST_OPCODE;
         default:  state_next = ST_OPCODE;
      endcase
      if (timed_out) begin
         state_next = ST_OPCODE;
         arg_next   = '0;
      end
   end

   // Outputs are loaded on entry to EXEC so they are valid exactly while execute is high.
   assign load_out = (state_next == ST_EXEC) && (state_reg != ST_EXEC);

   always_ff @(posedge clock or posedge extReset) begin
      if (extReset) begin
         state_reg  <= ST_OPCODE;
         opcode_reg <= '0;
         arg_reg    <= '0;
         op_reg     <= '0;
         data_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         opcode_reg <= opcode_next;
         arg_reg    <= arg_next;
         if (load_out) begin
            op_reg   <= opcode_next;
            data_reg <= arg_next;
         end
      end
   end

   assign op      = op_reg;
   assign data    = data_reg;
   assign execute = (state_reg == ST_EXEC);
   assign busy    = arg_state;

endmodule

// File: tb/tb_spi_receiver.sv
// Scoreboard bench for spi_receiver: directed SPI byte sequences push expected commands,
// a monitor pops and checks on every execute strobe.
module tb_spi_receiver;

   localparam int HALF = 3;

   typedef struct packed {
      logic [7:0]  op;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        ext_reset;
   logic        sclk;
   logic        cs;
   logic        rx;
   logic [7:0]  op;
   logic [31:0] data;
   logic        execute;
   logic        busy;

   exp_t exp_q[$];
   int   tests;
   int   fails;
   logic busy_seen;

   spi_receiver #(
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clock   (clk),
      .extReset(ext_reset),
      .sclk    (sclk),
      .cs      (cs),
      .rx      (rx),
      .op      (op),
      .data    (data),
      .execute (execute),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end else begin
         $display("[TB] ok %s = %h", name, act);
      end
   endtask

   task automatic push(input logic [7:0] o, input logic [31:0] d);
      exp_t e;
      e.op   = o;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         sclk = 1'b0;
         rx   = b[i];
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 8);
   endtask

   task automatic deselect();
      cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every execute strobe must match the oldest expected command.
   always @(negedge clk) begin
      exp_t e;
      if (!ext_reset) begin
         if (busy)
            busy_seen = 1'b1;
         if (execute) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_execute: got op=%h data=%h, required no execute", op, data);
            end else begin
               e = exp_q.pop_front();
               check("exec_op", 32'(op), 32'(e.op));
               check("exec_data", data, e.data);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tests     = 0;
      fails     = 0;
      busy_seen = 1'b0;
      ext_reset = 1'b1;
      sclk      = 1'b0;
      cs        = 1'b1;
      rx        = 1'b0;
      repeat (4) @(negedge clk);
      ext_reset = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_op", 32'(op), 32'h0);
      check("reset_data", data, 32'h0);
      check("reset_execute", 32'(execute), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);

      // Short command, busy must never rise
      busy_seen = 1'b0;
      cs = 1'b0;
      push(8'h01, 32'h0);
      send_byte(8'h01);
      wait_drain("short_drain");
      check("short_busy_never", 32'(busy_seen), 32'h0);
      deselect();

      // Long command, LSB argument byte first
      cs = 1'b0;
      push(8'h80, 32'h12345678);
      send_byte(8'h80);
      repeat (4) @(negedge clk);
      check("long_busy_after_op", 32'(busy), 32'h1);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
      wait_drain("long_drain");
      check("long_busy_done", 32'(busy), 32'h0);
      deselect();

      // Partial byte discarded by a cs pulse
      cs = 1'b0;
      send_bits(8'hE0, 3);
      cs = 1'b1;
      repeat (6) @(negedge clk);
      cs = 1'b0;
      repeat (3) @(negedge clk);
      push(8'h11, 32'h0);
      send_byte(8'h11);
      wait_drain("partial_drain");
      deselect();

      // Back-to-back short commands at maximum sclk rate
      cs = 1'b0;
      push(8'h02, 32'h0);
      push(8'h03, 32'h0);
      send_byte(8'h02);
      send_byte(8'h03);
      wait_drain("b2b_drain");
      deselect();
      check("op_held", 32'(op), 32'h03);

      // Reset in the middle of a long command
      cs = 1'b0;
      send_byte(8'h80);
      send_byte(8'h01);
      send_byte(8'h02);
      repeat (6) @(negedge clk);
      check("mid_long_busy", 32'(busy), 32'h1);
      ext_reset = 1'b1;
      #1;
      check("async_reset_op", 32'(op), 32'h0);
      check("async_reset_busy", 32'(busy), 32'h0);
      repeat (3) @(negedge clk);
      ext_reset = 1'b0;
      repeat (2) @(negedge clk);
      check("post_reset_data", data, 32'h0);
      check("post_reset_execute", 32'(execute), 32'h0);
      push(8'h00, 32'h0);
      send_byte(8'h00);
      wait_drain("post_reset_drain");
      deselect();

`ifdef SPI_RX_TIMEOUT_EN
      // Partial long command abandoned after the idle timeout
      cs = 1'b0;
      send_byte(8'h81);
      send_byte(8'h55);
      repeat (64) @(negedge clk);
      check("timeout_busy_cleared", 32'(busy), 32'h0);
      push(8'h00, 32'h0);
      send_byte(8'h00);
      wait_drain("timeout_drain");
      deselect();
`endif

      repeat (20) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
